instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 94 +++++++++
 tb/tb_instr_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: keeps a 2-entry prefetch FIFO filled from instruction
// memory, hands the head word to IR on LDIR, and flushes and redirects on pc_load.
module instr_fetch_unit (
    input  logic       clk,
    input  logic       rst_n,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [5:0] mem_rdata,
    input  logic       LDIR,
    input  logic       pc_load,
    input  logic [7:0] pc_in,
    output logic [5:0] IR,
    output logic [1:0] buf_count,
    output logic       stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_ptr;
    logic [5:0] r_fifo [2];
    logic [1:0] r_count;
    logic [5:0] r_ir;

    logic       w_push;
    logic       w_pop;
    logic [1:0] w_count_next;
    logic [1:0] w_wr_idx;

    // pc_load has top priority: it blocks both the pop and the push
    always_comb begin
        w_pop        = LDIR && (r_count != 2'd0) && !pc_load;
        w_push       = (r_state == S_REQ) && mem_ack && !pc_load &&
                       ((r_count != 2'd2) || w_pop);
        w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
        w_wr_idx     = r_count - {1'b0, w_pop};
    end

    // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        if (pc_load) begin
            w_next_state = S_REQ;
        end else begin
            case (r_state)
                S_IDLE:  w_next_state = S_REQ;
                S_REQ:   if (w_push && (w_count_next == 2'd2)) w_next_state = S_HOLD;
                S_HOLD:  if (w_pop) w_next_state = S_REQ;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= 8'h00;
            r_count <= 2'd0;
            r_ir    <= 6'b000000;
        end else begin
            r_state <= w_next_state;
            if (pc_load) begin
                r_ptr   <= pc_in;
                r_count <= 2'd0;
            end else begin
                if (w_push) r_ptr <= r_ptr + 8'd1;
                r_count <= w_count_next;
            end
            if (w_pop) r_ir <= r_fifo[0];
        end
    end

    // NOTE: FIFO storage is not reset; r_count qualifies every entry, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (w_push && (w_wr_idx == 2'd0)) r_fifo[0] <= mem_rdata;
        else if (w_pop)                   r_fifo[0] <= r_fifo[1];
        if (w_push && (w_wr_idx == 2'd1)) r_fifo[1] <= mem_rdata;
    end

    assign mem_req   = (r_state == S_REQ);
    assign mem_addr  = r_ptr;
    assign IR        = r_ir;
    assign buf_count = r_count;
    // Gated by rst_n so stall reads 0 while reset is held
    assign stall     = rst_n && LDIR && (r_count == 2'd0) && !pc_load;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, reset
// corner sequences, then a random run against a queue-based reference model.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [5:0] mem_rdata;
    logic       LDIR;
    logic       pc_load;
    logic [7:0] pc_in;
    logic [5:0] IR;
    logic [1:0] buf_count;
    logic       stall;

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .LDIR      (LDIR),
        .pc_load   (pc_load),
        .pc_in     (pc_in),
        .IR        (IR),
        .buf_count (buf_count),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ack;
        logic [5:0] rdata;
        logic       ldir;
        logic       pcl;
        logic [7:0] pcin;
        logic       exp_req;    // before the edge
        logic [7:0] exp_addr;   // before the edge
        logic       exp_stall;  // before the edge
        logic [1:0] exp_count;  // after the edge
        logic [5:0] exp_ir;     // after the edge
    } vec_t;

    vec_t vecs[17];

    // Reference model; the FIFO contents are the scoreboard queue
    int         m_state;  // 0 idle, 1 req, 2 hold
    logic [7:0] m_ptr;
    logic [5:0] m_ir;
    logic [5:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1: drive inputs, check combinational outputs, clock, check registers
    task automatic step(input logic ack, input logic [5:0] rdata, input logic ldir,
                        input logic pcl, input logic [7:0] pcin,
                        input logic e_req, input logic [7:0] e_addr, input logic e_stall,
                        input logic [1:0] e_count, input logic [5:0] e_ir, input string tag);
        mem_ack   = ack;
        mem_rdata = rdata;
        LDIR      = ldir;
        pc_load   = pcl;
        pc_in     = pcin;
        #1;
        check({tag, " mem_req"},  32'(mem_req),  32'(e_req));
        check({tag, " mem_addr"}, 32'(mem_addr), 32'(e_addr));
        check({tag, " stall"},    32'(stall),    32'(e_stall));
        @(posedge clk);
        #1;
        check({tag, " buf_count"}, 32'(buf_count), 32'(e_count));
        check({tag, " IR"},        32'(IR),        32'(e_ir));
    endtask

    // One random cycle: expectations come from the model, not the DUT
    task automatic model_step(input logic ack, input logic [5:0] rdata, input logic ldir,
                              input logic pcl, input logic [7:0] pcin, input string tag);
        logic       e_req;
        logic [7:0] e_addr;
        logic       e_stall;
        logic       popped;
        logic       pushed;
        e_req   = (m_state == 1);
        e_addr  = m_ptr;
        e_stall = ldir && (sb_q.size() == 0) && !pcl;
        if (pcl) begin
            m_ptr   = pcin;
            sb_q.delete();
            m_state = 1;
        end else begin
            popped = ldir && (sb_q.size() > 0);
            pushed = (m_state == 1) && ack;
            if (popped) m_ir = sb_q.pop_front();
            if (pushed) begin
                sb_q.push_back(rdata);
                m_ptr = m_ptr + 8'd1;
            end
            case (m_state)
                0: m_state = 1;
                1: if (pushed && sb_q.size() == 2) m_state = 2;
                default: if (popped) m_state = 1;
            endcase
        end
        step(ack, rdata, ldir, pcl, pcin, e_req, e_addr, e_stall, 2'(sb_q.size()), m_ir, tag);
    endtask

    initial begin
        //          ack  rdata  ldir pcl  pcin   req  addr   stall cnt  ir
        vecs[0]  = '{1'b1, 6'h3F, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0, 6'h00}; // idle ignores ack
        vecs[1]  = '{1'b1, 6'h01, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 2'd1, 6'h00}; // 1-cycle latency
        vecs[2]  = '{1'b1, 6'h02, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 2'd2, 6'h00}; // fill
        vecs[3]  = '{1'b1, 6'h3F, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 2'd2, 6'h00}; // hold ignores ack
        vecs[4]  = '{1'b0, 6'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 2'd1, 6'h01}; // pop from full
        vecs[5]  = '{1'b0, 6'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 2'd1, 6'h01}; // back to req
        vecs[6]  = '{1'b0, 6'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 2'd0, 6'h02};
        vecs[7]  = '{1'b0, 6'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 2'd0, 6'h02}; // empty stall
        vecs[8]  = '{1'b1, 6'h05, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 2'd1, 6'h02}; // no bypass
        vecs[9]  = '{1'b1, 6'h06, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 2'd1, 6'h05}; // push+pop
        vecs[10] = '{1'b1, 6'h07, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 2'd2, 6'h05};
        vecs[11] = '{1'b1, 6'h3F, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h05, 1'b0, 2'd0, 6'h05}; // redirect while full
        vecs[12] = '{1'b0, 6'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 2'd0, 6'h05};
        vecs[13] = '{1'b1, 6'h0A, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 2'd1, 6'h05}; // 0xFF wraps
        vecs[14] = '{1'b0, 6'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 2'd0, 6'h0A};
        vecs[15] = '{1'b0, 6'h00, 1'b1, 1'b1, 8'h10, 1'b1, 8'h00, 1'b0, 2'd0, 6'h0A}; // pc_load masks stall
        vecs[16] = '{1'b0, 6'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 2'd0, 6'h0A};

        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 6'h00;
        LDIR      = 1'b1;
        pc_load   = 1'b0;
        pc_in     = 8'h00;
        #12;
        check("reset mem_req",   32'(mem_req),   32'd0);
        check("reset mem_addr",  32'(mem_addr),  32'h00);
        check("reset buf_count", 32'(buf_count), 32'd0);
        check("reset IR",        32'(IR),        32'h00);
        check("reset stall",     32'(stall),     32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        LDIR  = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].ack, vecs[i].rdata, vecs[i].ldir, vecs[i].pcl, vecs[i].pcin,
                 vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_stall,
                 vecs[i].exp_count, vecs[i].exp_ir, $sformatf("vec%0d", i));
        end

        // Reset asserted mid-request with an ack pending
        mem_ack   = 1'b1;
        mem_rdata = 6'h3F;
        LDIR      = 1'b1;
        pc_load   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset mem_req",   32'(mem_req),   32'd0);
        check("midreset mem_addr",  32'(mem_addr),  32'h00);
        check("midreset buf_count", 32'(buf_count), 32'd0);
        check("midreset IR",        32'(IR),        32'h00);
        check("midreset stall",     32'(stall),     32'd0);
        @(posedge clk);
        #1;
        check("heldreset buf_count", 32'(buf_count), 32'd0);
        check("heldreset mem_addr",  32'(mem_addr),  32'h00);
        rst_n   = 1'b1;
        mem_ack = 1'b0;
        LDIR    = 1'b0;
        #1;
        check("release idle mem_req", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;
        check("release req mem_req",   32'(mem_req),   32'd1);
        check("release req mem_addr",  32'(mem_addr),  32'h00);
        check("release req buf_count", 32'(buf_count), 32'd0);

        // Random traffic against the model, starting from S_REQ at address 0
        m_state = 1;
        m_ptr   = 8'h00;
        m_ir    = 6'h00;
        sb_q.delete();
        for (int i = 0; i < 400; i++) begin
            model_step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                       1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0),
                       8'($urandom_range(0, 255)), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
